// File: rtl/regf_reader_pkg.sv
// -----------------------------------------------------------------------------
// regf_reader_pkg
// Shared constants and types for the register-file read-out engine:
//   N_REGS, WIDTH, ADDR_W  - geometry of the 4x8 register file
//   state_e                - FSM state encoding (IDLE=0, READ=1, SEND=2, DONE=3)
//   addr_inc()             - wrapping address increment modulo N_REGS
// -----------------------------------------------------------------------------
package regf_reader_pkg;

    localparam int N_REGS = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // The explicit compare keeps the wrap correct should N_REGS ever stop
    // being a power of two.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(N_REGS - 1)) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/regf_reader_if.sv
// -----------------------------------------------------------------------------
// regf_reader_if
// Byte stream carrying the read-out data from regf_reader to its sink.
//   out_data  - streamed byte
//   out_valid - out_data valid
//   out_ready - sink accepts when high with out_valid at a rising edge
//   out_last  - marks the final byte of a burst
// Modports: master (stream source, regf_reader), slave (stream sink).
// -----------------------------------------------------------------------------
interface regf_reader_if;
    import regf_reader_pkg::*;

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regf_reader.sv
// -----------------------------------------------------------------------------
// regf_reader
// Sequenced read-out engine for the 4x8 register file. A start pulse walks the
// file's read address over a contiguous, wrapping range; each byte is captured
// and streamed out with a last marker while an 8-bit checksum accumulates.
//
// Ports:
//   clk        - rising-edge clock
//   rst_b      - asynchronous active-low reset
//   start      - request a read-out (sampled only in IDLE)
//   first_addr - first register to read
//   len_m1     - number of registers to read minus one
//   rd_addr    - registered read address to the register file
//   rd_data    - combinational read data from the register file
//   out_if     - byte stream (master side)
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse after the last byte is accepted
//   checksum   - sum mod 256 of bytes accepted in the current/last burst
//
// state | meaning
// IDLE  | waiting for start; checksum holds the previous burst's result
// READ  | one cycle: rd_addr is stable, rd_data is captured into out_data
// SEND  | out_valid held until the sink accepts; then next byte or DONE
// DONE  | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module regf_reader
    import regf_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] len_m1,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    regf_reader_if.master     out_if,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [WIDTH-1:0]  csum_q, csum_d;
    logic              hs;

    assign hs = valid_q & out_if.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_READ;
            ST_READ: state_d = ST_SEND;
            ST_SEND: if (hs) state_d = last_q ? ST_DONE : ST_READ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Address/remaining counters and stream registers beside the FSM
    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        csum_d  = csum_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = first_addr;
                    rem_d  = len_m1;
                    csum_d = '0;
                end
            end
            ST_READ: begin
                data_d  = rd_data;
                valid_d = 1'b1;
                last_d  = (rem_q == '0);
            end
            ST_SEND: begin
                if (hs) begin
                    csum_d  = csum_q + data_q;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    // The address only advances when another byte follows, so
                    // rd_addr keeps pointing at the final register after a burst.
                    if (!last_q) begin
                        addr_d = addr_inc(addr_q);
                        rem_d  = rem_q - ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            csum_q  <= csum_d;
        end
    end

    assign rd_addr          = addr_q;
    assign checksum         = csum_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_regf_reader.sv
// -----------------------------------------------------------------------------
// tb_regf_reader
// Directed bench for regf_reader: a behavioural 4x8 register file drives
// rd_data from rd_addr, a table of burst vectors is applied in a loop, and
// reset-abort is exercised by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_regf_reader;
    import regf_reader_pkg::*;

    logic              clk;
    logic              rst_b;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] len_m1;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  checksum;

    regf_reader_if s_if ();

    regf_reader dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (start),
        .first_addr (first_addr),
        .len_m1     (len_m1),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_if     (s_if.master),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    logic [7:0] regs [4];
    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]      fa;
        logic [1:0]      lm;
        int              stall;
        logic            poke;     // pulse start again mid-burst
        int              wr_edge;  // -1: no register write during the burst
        logic [1:0]      wr_addr;
        logic [7:0]      wr_val;
        logic [3:0][7:0] pre;      // pre[i] = register i
        int              nbytes;
        logic [3:0][7:0] exp_b;
        logic [7:0]      exp_cs;
        int              exp_lat;  // edges after the accepting edge until done is seen
    } vec_t;

    vec_t vecs [6];

    // Filled by run_burst
    logic [7:0] got_d [4];
    logic       got_l [4];
    logic [1:0] got_a [4];
    int         got_n;
    int         got_lat;
    logic [7:0] cs_at_start;

    task automatic run_burst(input vec_t v);
        int edges = 0;
        int stalled = 0;
        logic fin = 1'b0;
        got_n = 0;
        got_lat = -1;
        @(negedge clk);
        start = 1'b1;
        first_addr = v.fa;
        len_m1 = v.lm;
        s_if.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cs_at_start = checksum;
        while (!fin && edges < 100) begin
            if (done) begin
                got_lat = edges;
                fin = 1'b1;
            end else begin
                if (v.poke && edges == 3) begin
                    start = 1'b1;
                    first_addr = 2'd2;
                    len_m1 = 2'd0;
                end else begin
                    start = 1'b0;
                end
                if (v.wr_edge == edges) regs[v.wr_addr] = v.wr_val;
                if (s_if.out_valid && stalled < v.stall) begin
                    s_if.out_ready = 1'b0;
                    stalled++;
                    chk("stall_data", {24'd0, s_if.out_data}, {24'd0, v.exp_b[0]});
                end else begin
                    s_if.out_ready = 1'b1;
                end
                if (s_if.out_valid && s_if.out_ready) begin
                    if (got_n < 4) begin
                        got_d[got_n] = s_if.out_data;
                        got_l[got_n] = s_if.out_last;
                        got_a[got_n] = rd_addr;
                    end
                    got_n++;
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) chk("burst_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // 0: full burst
        vecs[0] = '{fa:2'd0, lm:2'd3, stall:0, poke:1'b0, wr_edge:-1, wr_addr:2'd0, wr_val:8'h00,
                    pre:{8'h44, 8'h33, 8'h22, 8'h11}, nbytes:4,
                    exp_b:{8'h44, 8'h33, 8'h22, 8'h11}, exp_cs:8'hAA, exp_lat:8};
        // 1: wrap 3 -> 0
        vecs[1] = '{fa:2'd3, lm:2'd1, stall:0, poke:1'b0, wr_edge:-1, wr_addr:2'd0, wr_val:8'h00,
                    pre:{8'h44, 8'h33, 8'h22, 8'h11}, nbytes:2,
                    exp_b:{8'h00, 8'h00, 8'h11, 8'h44}, exp_cs:8'h55, exp_lat:4};
        // 2: back-pressure on the first byte
        vecs[2] = '{fa:2'd0, lm:2'd3, stall:5, poke:1'b0, wr_edge:-1, wr_addr:2'd0, wr_val:8'h00,
                    pre:{8'h44, 8'h33, 8'h22, 8'h11}, nbytes:4,
                    exp_b:{8'h44, 8'h33, 8'h22, 8'h11}, exp_cs:8'hAA, exp_lat:13};
        // 3: single register
        vecs[3] = '{fa:2'd2, lm:2'd0, stall:0, poke:1'b0, wr_edge:-1, wr_addr:2'd0, wr_val:8'h00,
                    pre:{8'hFF, 8'hFF, 8'hFF, 8'hFF}, nbytes:1,
                    exp_b:{8'h00, 8'h00, 8'h00, 8'hFF}, exp_cs:8'hFF, exp_lat:2};
        // 4: checksum mod-256 wrap, cleared from the previous 0xFF
        vecs[4] = '{fa:2'd1, lm:2'd1, stall:0, poke:1'b0, wr_edge:-1, wr_addr:2'd0, wr_val:8'h00,
                    pre:{8'h80, 8'h80, 8'h80, 8'h80}, nbytes:2,
                    exp_b:{8'h00, 8'h00, 8'h80, 8'h80}, exp_cs:8'h00, exp_lat:4};
        // 5: start while busy ignored; reg1 rewritten to 0x99 before its READ
        vecs[5] = '{fa:2'd0, lm:2'd3, stall:0, poke:1'b1, wr_edge:1, wr_addr:2'd1, wr_val:8'h99,
                    pre:{8'h44, 8'h33, 8'h22, 8'h11}, nbytes:4,
                    exp_b:{8'h44, 8'h33, 8'h99, 8'h11}, exp_cs:8'h21, exp_lat:8};

        rst_b = 1'b0;
        start = 1'b0;
        first_addr = '0;
        len_m1 = '0;
        s_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, s_if.out_valid}, 32'd0);
        chk("rst_cs", {24'd0, checksum}, 32'd0);
        chk("rst_addr", {30'd0, rd_addr}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < 4; r++) regs[r] = vecs[v].pre[r];
            run_burst(vecs[v]);
            chk($sformatf("v%0d_cs_clear", v), {24'd0, cs_at_start}, 32'd0);
            chk($sformatf("v%0d_nbytes", v), got_n, vecs[v].nbytes);
            for (int b = 0; b < 4; b++) begin
                if (b < vecs[v].nbytes && b < got_n) begin
                    chk($sformatf("v%0d_b%0d_data", v, b), {24'd0, got_d[b]}, {24'd0, vecs[v].exp_b[b]});
                    chk($sformatf("v%0d_b%0d_last", v, b), {31'd0, got_l[b]},
                        (b == vecs[v].nbytes - 1) ? 32'd1 : 32'd0);
                    chk($sformatf("v%0d_b%0d_addr", v, b), {30'd0, got_a[b]},
                        {30'd0, 2'(vecs[v].fa + 2'(b))});
                end
            end
            chk($sformatf("v%0d_latency", v), got_lat, vecs[v].exp_lat);
            chk($sformatf("v%0d_cs", v), {24'd0, checksum}, {24'd0, vecs[v].exp_cs});
            chk($sformatf("v%0d_busy_in_done", v), {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_idle_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_done_pulse", v), {31'd0, done}, 32'd0);
            chk($sformatf("v%0d_cs_hold", v), {24'd0, checksum}, {24'd0, vecs[v].exp_cs});
        end

        // Reset asserted mid-burst while a byte waits in SEND
        for (int r = 0; r < 4; r++) regs[r] = vecs[0].pre[r];
        @(negedge clk);
        s_if.out_ready = 1'b0;
        start = 1'b1;
        first_addr = 2'd1;
        len_m1 = 2'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, s_if.out_valid}, 32'd1);
        chk("pre_rst_data", {24'd0, s_if.out_data}, 32'h22);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_addr", {30'd0, rd_addr}, 32'd0);
        chk("arst_data", {24'd0, s_if.out_data}, 32'd0);
        chk("arst_valid", {31'd0, s_if.out_valid}, 32'd0);
        chk("arst_last", {31'd0, s_if.out_last}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_cs", {24'd0, checksum}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        run_burst(vecs[0]);
        chk("post_rst_nbytes", got_n, 4);
        for (int b = 0; b < 4; b++) begin
            if (b < got_n) chk($sformatf("post_rst_b%0d", b), {24'd0, got_d[b]}, {24'd0, vecs[0].exp_b[b]});
        end
        chk("post_rst_latency", got_lat, 8);
        chk("post_rst_cs", {24'd0, checksum}, 32'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regf_reader.md
# regf_reader

Sequenced read-out engine for the 4x8 register file. On a start pulse it drives the file's read address through a contiguous, wrapping range of registers. It captures each returned byte and streams it out over a valid/ready handshake with a last marker and a running 8-bit checksum. It sits on the read port of the register file, opposite the write-side logic.

## Interface
- N_REGS, 4, number of registers in the file (address width = 2)
- WIDTH, 8, data width
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous active-low reset
- start  in  1  request a read-out; sampled only in IDLE
- first_addr  in  2  first register to read
- len_m1  in  2  registers to read minus one (0..3 -> 1..4 registers)
- rd_addr  out  2  read address to the register file (registered)
- rd_data  in  8  combinational read data from the register file
- out_data  out  8  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts when high together with out_valid at a rising edge
- out_last  out  1  high with the final byte of the burst
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last byte is accepted
- checksum  out  8  sum mod 256 of bytes accepted in the current or last burst

## Operation
- States: IDLE, READ, SEND, DONE. The state register is reset to IDLE.
- IDLE: if start=1 at an edge:
  - rd_addr <= first_addr, remaining <= len_m1, checksum <= 0, state <= READ.
  - Otherwise hold.
- READ (exactly one cycle):
  - out_data <= rd_data, out_valid <= 1, out_last <= (remaining==0), state <= SEND.
- SEND: hold out_data, out_valid and out_last stable until out_valid and out_ready are both high at an edge. On that edge:
  - checksum <= checksum + out_data, truncated to 8 bits.
  - out_valid <= 0, out_last <= 0.
  - If out_last was 1: state <= DONE.
  - Otherwise: rd_addr <= rd_addr+1 (3 wraps to 0), remaining <= remaining-1, state <= READ.
- DONE: done=1 for this cycle only, state <= IDLE. checksum holds its final value until the next accepted start.
- start while busy is ignored and is not queued.
- A write to the register file at the READ edge is not visible in that capture; the byte taken is the value on rd_data during the READ cycle.
- Reset, asserted at any time including mid-burst, aborts immediately. All outputs go to 0: rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, checksum=0.

## Timing
- Start accepted at edge E0 -> READ during cycle E0..E1 -> out_valid high from E1.
- With out_ready held high, each byte occupies 2 cycles (READ + SEND). A burst of n bytes takes 2n+1 cycles from E0 until done is pulsed.
- Back-pressure: every extra cycle out_ready stays low adds one cycle. out_data must not change while out_valid=1.
- busy rises on the edge that accepts start. It falls on the edge leaving DONE. A new start is therefore accepted no earlier than the cycle after done.
- rd_addr changes only at start acceptance or at a byte handshake, so it is stable for the full READ cycle.

## Structure
- Shared package holds:
  - N_REGS, WIDTH and ADDR_W=2.
  - The 2-bit state encoding: IDLE=0, READ=1, SEND=2, DONE=3.
- Single flat module, with no sub-module needed.
- The address counter (wrapping, modulo N_REGS) and the remaining counter live inline beside the FSM.
- Integration: instantiate next to regf1_4x8, connecting rd_addr and rd_data directly.

## Test plan
- Preload registers 0..3 with 0x11, 0x22, 0x33, 0x44. start with first_addr=0, len_m1=3, out_ready=1 -> expected:
  - Bytes 0x11, 0x22, 0x33, 0x44 with out_last only on 0x44.
  - done pulsed 9 cycles after start.
  - checksum=0xAA.
- Wrap-around: first_addr=3, len_m1=1 -> bytes 0x44 then 0x11 (rd_addr 3 then 0), checksum=0x55.
- Back-pressure: out_ready low for 5 cycles during the first byte -> out_data stays at 0x11 with out_valid=1 throughout. The sequence and checksum are unchanged; done is delayed by 5 cycles.
- Single register: first_addr=2, len_m1=0 with registers holding 0xFF -> expected:
  - One byte 0xFF with out_last=1.
  - checksum=0xFF.
  - Then a second burst over two registers both holding 0x80 gives checksum=0x00 (mod-256 wrap), with checksum cleared at start.
- start pulsed again while busy -> ignored, and the burst completes unaltered. Write 0x99 to register 1 during a burst before its READ cycle -> 0x99 is streamed.
- Assert rst_b low during SEND -> all outputs 0 immediately, state IDLE. After release, a new start runs a clean burst.
